// File: rtl/sbus_frame_ctrl.sv
// S.BUS frame sequencer: syncs on header after an idle gap, assembles 25-byte frames, commits good ones to a channel shadow.
// Latency: frame_valid/shadow/flags one clock after the footer strobe; ch_data one clock after ch_sel.
// Backpressure: none, every rx_valid strobe is consumed; define SBUS2_FOOTER_EN to accept S.BUS2 footers and add sbus2_slot.
module sbus_frame_ctrl #(
    parameter int GAP_CYCLES   = 25000,
    parameter int BYTE_TIMEOUT = 12500,
    parameter int LOST_CYCLES  = 5000000,
    parameter int CNT_W        = 23
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_pe,
    input  logic        rx_fe,
    output logic        rx_en,
    input  logic [3:0]  ch_sel,
    output logic [10:0] ch_data,
    output logic        ch17,
    output logic        ch18,
    output logic        failsafe,
    output logic        frame_lost,
    output logic        frame_valid,
    output logic        link_lost,
    output logic [7:0]  err_cnt
`ifdef SBUS2_FOOTER_EN
    ,
    output logic [1:0]  sbus2_slot
`endif
);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {S_GAP, S_HDR, S_DATA, S_FLAGS, S_FOOTER} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   tmr, tmr_nxt;
    logic [CNT_W-1:0]   loss_tmr;
    logic [4:0]         idx, idx_nxt;
    logic [175:0]       asm_vec;
    logic [3:0]         asm_flags;
    logic [175:0]       shadow;
    logic [7:0]         asm_base;
    logic [7:0]         ch_base;
    logic               rx_err;
    logic               footer_ok;
    logic               store_en;
    logic               flags_en;
    logic               commit;
    logic               drop;

    assign rx_err   = rx_pe | rx_fe;
    assign asm_base = {idx, 3'b000};
    assign ch_base  = 8'(ch_sel) * 8'd11;

`ifdef SBUS2_FOOTER_EN
    assign footer_ok = (rx_data == 8'h00) || ((rx_data[7:6] == 2'b00) && (rx_data[3:0] == 4'h4));
`else
    assign footer_ok = (rx_data == 8'h00);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_GAP;
            tmr   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            idx   <= idx_nxt;
        end
    end

    // One timer serves as the gap timer in GAP and the byte timer inside a frame.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        idx_nxt   = idx;
        store_en  = 1'b0;
        flags_en  = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            S_GAP: begin
                if (rx_valid) begin
                    tmr_nxt = '0;
                end else if (tmr == GAP_LAST) begin
                    state_nxt = S_HDR;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + CNT_ONE;
                end
            end
            S_HDR: begin
                if (rx_valid) begin
                    tmr_nxt = '0;
                    if (rx_data == 8'h0F && !rx_err) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_GAP;
                        drop      = 1'b1;
                    end
                end
            end
            default: begin
                if (rx_valid) begin
                    tmr_nxt = '0;
                    if (rx_err) begin
                        state_nxt = S_GAP;
                        drop      = 1'b1;
                    end else if (state == S_DATA) begin
                        store_en = 1'b1;
                        if (idx == 5'd21) begin
                            state_nxt = S_FLAGS;
                        end else begin
                            idx_nxt = idx + 5'd1;
                        end
                    end else if (state == S_FLAGS) begin
                        flags_en  = 1'b1;
                        state_nxt = S_FOOTER;
                    end else begin
                        state_nxt = S_GAP;
                        commit    = footer_ok;
                        drop      = !footer_ok;
                    end
                end else if (tmr == BYTE_LAST) begin
                    state_nxt = S_GAP;
                    tmr_nxt   = '0;
                    drop      = 1'b1;
                end else begin
                    tmr_nxt = tmr + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_en       <= 1'b0;
            asm_vec     <= '0;
            asm_flags   <= '0;
            shadow      <= '0;
            ch_data     <= '0;
            ch17        <= 1'b0;
            ch18        <= 1'b0;
            failsafe    <= 1'b0;
            frame_lost  <= 1'b0;
            frame_valid <= 1'b0;
            err_cnt     <= '0;
            loss_tmr    <= '0;
            link_lost   <= 1'b1;
        end else begin
            rx_en       <= 1'b1;
            frame_valid <= commit;
            ch_data     <= shadow[ch_base +: 11];
            if (store_en) begin
                asm_vec[asm_base +: 8] <= rx_data;
            end
            if (flags_en) begin
                asm_flags <= rx_data[3:0];
            end
            if (commit) begin
                shadow     <= asm_vec;
                ch17       <= asm_flags[0];
                ch18       <= asm_flags[1];
                frame_lost <= asm_flags[2];
                failsafe   <= asm_flags[3];
            end
            if (drop && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            // Loss timer parks at its last value so link_lost stays up until the next commit.
            if (commit) begin
                loss_tmr  <= '0;
                link_lost <= 1'b0;
            end else if (loss_tmr == LOST_LAST) begin
                link_lost <= 1'b1;
            end else begin
                loss_tmr <= loss_tmr + CNT_ONE;
            end
        end
    end

`ifdef SBUS2_FOOTER_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sbus2_slot <= 2'b00;
        end else if (commit) begin
            sbus2_slot <= rx_data[5:4];
        end
    end
`endif

endmodule

// File: tb/tb_sbus_frame_ctrl.sv
// Randomized frame-level bench for sbus_frame_ctrl, scored against a frame-outcome model of the S.BUS rules.
module tb_sbus_frame_ctrl;

    localparam int GAP  = 100;
    localparam int BTO  = 50;
    localparam int LOST = 2000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pe;
    logic        rx_fe;
    logic        rx_en;
    logic [3:0]  ch_sel;
    logic [10:0] ch_data;
    logic        ch17;
    logic        ch18;
    logic        failsafe;
    logic        frame_lost;
    logic        frame_valid;
    logic        link_lost;
    logic [7:0]  err_cnt;
`ifdef SBUS2_FOOTER_EN
    logic [1:0]  sbus2_slot;
`endif

    sbus_frame_ctrl #(
        .GAP_CYCLES   (GAP),
        .BYTE_TIMEOUT (BTO),
        .LOST_CYCLES  (LOST),
        .CNT_W        (23)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_pe       (rx_pe),
        .rx_fe       (rx_fe),
        .rx_en       (rx_en),
        .ch_sel      (ch_sel),
        .ch_data     (ch_data),
        .ch17        (ch17),
        .ch18        (ch18),
        .failsafe    (failsafe),
        .frame_lost  (frame_lost),
        .frame_valid (frame_valid),
        .link_lost   (link_lost),
        .err_cnt     (err_cnt)
`ifdef SBUS2_FOOTER_EN
        ,
        .sbus2_slot  (sbus2_slot)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_bad    = 0;
    int         fv_count = 0;
    int         mdl_err  = 0;
    logic [7:0] fb [25];
    logic [7:0] mdl_bytes [22];
    logic [3:0] mdl_flags = 4'h0;
    logic [1:0] mdl_slot  = 2'b00;

    always @(negedge clk) begin
        if (frame_valid) fv_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_pe    = pe;
        rx_fe    = fe;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_pe    = 1'b0;
        rx_fe    = 1'b0;
    endtask

    // Positions: 0 header, 1..22 data, 23 flags, 24 footer; stops before position stop_pos.
    task automatic send_frame(input int err_pos, input bit err_fe, input int stop_pos, input int min_sp, input int max_sp);
        for (int i = 0; i < 25 && i < stop_pos; i++) begin
            if (i > 0) idle(int'($urandom_range(max_sp, min_sp)));
            send_byte(fb[i], (i == err_pos) && !err_fe, (i == err_pos) && err_fe);
        end
    endtask

    function automatic bit footer_ok_m(input logic [7:0] f);
`ifdef SBUS2_FOOTER_EN
        return f == 8'h00 || f == 8'h04 || f == 8'h14 || f == 8'h24 || f == 8'h34;
`else
        return f == 8'h00;
`endif
    endfunction

    // Channel n = bits 11n..11n+10 of the little-endian byte stream.
    function automatic logic [10:0] model_ch(input int n);
        logic [10:0] v;
        int          p;
        v = '0;
        for (int b = 0; b < 11; b++) begin
            p    = 11 * n + b;
            v[b] = mdl_bytes[p / 8][p % 8];
        end
        return v;
    endfunction

    task automatic fill_plan_frame(input logic [7:0] flg, input logic [7:0] ftr);
        fb[0] = 8'h0F;
        for (int i = 1; i < 23; i++) fb[i] = 8'h00;
        fb[1]  = 8'hFF;
        fb[2]  = 8'h07;
        fb[23] = flg;
        fb[24] = ftr;
    endtask

    task automatic run_frame(input string tag, input int err_pos, input bit err_fe, input int stop_pos,
                             input int min_sp, input int max_sp);
        int fv0;
        bit exp_commit;
        idle(GAP + 130);
        fv0 = fv_count;
        exp_commit = (fb[0] == 8'h0F) && (err_pos < 0) && (stop_pos >= 25) && footer_ok_m(fb[24]);
        send_frame(err_pos, err_fe, stop_pos, min_sp, max_sp);
        if (exp_commit) begin
            for (int i = 0; i < 22; i++) mdl_bytes[i] = fb[i + 1];
            mdl_flags = fb[23][3:0];
            mdl_slot  = fb[24][5:4];
        end else if (mdl_err < 255) begin
            mdl_err++;
        end
        if (stop_pos < 25) idle(BTO + 10);
        check_val({tag, " frame_valid"}, 32'(frame_valid), 32'(exp_commit));
        if (exp_commit) check_val({tag, " link_lost"}, 32'(link_lost), 32'd0);
        idle(1);
        check_val({tag, " pulse_count"}, 32'(fv_count - fv0), 32'(exp_commit));
        check_val({tag, " err_cnt"}, 32'(err_cnt), 32'(mdl_err));
        check_val({tag, " flags"}, 32'({failsafe, frame_lost, ch18, ch17}), 32'(mdl_flags));
`ifdef SBUS2_FOOTER_EN
        check_val({tag, " sbus2_slot"}, 32'(sbus2_slot), 32'(mdl_slot));
`endif
        for (int k = 0; k < 2; k++) begin
            int n;
            n      = int'($urandom_range(15, 0));
            ch_sel = 4'(n);
            idle(1);
            check_val({tag, " ch_data"}, 32'(ch_data), 32'(model_ch(n)));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0;
        for (int i = 0; i < 22; i++) mdl_bytes[i] = 8'h00;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_pe    = 1'b0;
        rx_fe    = 1'b0;
        ch_sel   = 4'd0;
        idle(3);
        check_val("rst rx_en", 32'(rx_en), 32'd0);
        check_val("rst link_lost", 32'(link_lost), 32'd1);
        check_val("rst err_cnt", 32'(err_cnt), 32'd0);
        check_val("rst outputs", 32'({ch_data, ch17, ch18, failsafe, frame_lost, frame_valid}), 32'd0);
        resetn = 1'b1;
        idle(1);
        check_val("rx_en after release", 32'(rx_en), 32'd1);

        // Plan frame at 20-cycle spacing.
        fill_plan_frame(8'h0C, 8'h00);
        run_frame("plan", -1, 1'b0, 25, 19, 19);
        ch_sel = 4'd0;
        idle(1);
        check_val("plan ch0", 32'(ch_data), 32'h7FF);
        ch_sel = 4'd1;
        idle(1);
        check_val("plan ch1", 32'(ch_data), 32'h000);
        check_val("plan fs/fl/ch17", 32'({failsafe, frame_lost, ch17}), 32'b110);

        // Parity error on data byte 10 drops the frame; the retry commits.
        fill_plan_frame(8'h0C, 8'h00);
        fb[12] = 8'h55;
        run_frame("pe10", 11, 1'b0, 25, 0, 20);
        ch_sel = 4'd0;
        idle(1);
        check_val("pe10 shadow kept", 32'(ch_data), 32'h7FF);
        check_val("pe10 err_cnt", 32'(err_cnt), 32'd1);
        run_frame("retry", -1, 1'b0, 25, 0, 20);

        // Mid-frame stall: abort exactly BYTE_TIMEOUT clocks after byte 5.
        fill_plan_frame(8'h03, 8'h00);
        idle(GAP + 130);
        send_frame(-1, 1'b0, 7, 0, 0);
        idle(BTO - 1);
        check_val("timeout before", 32'(err_cnt), 32'(mdl_err));
        idle(1);
        mdl_err++;
        check_val("timeout abort", 32'(err_cnt), 32'(mdl_err));
        idle(30);
        fv0 = fv_count;
        send_frame(-1, 1'b0, 25, 0, 3);
        idle(5);
        check_val("early hdr ignored", 32'(fv_count - fv0), 32'd0);
        check_val("early hdr no err", 32'(err_cnt), 32'(mdl_err));

        // S.BUS2 footer: accepted only when the feature is built in.
        fill_plan_frame(8'h01, 8'h04);
        run_frame("ftr04", -1, 1'b0, 25, 0, 10);

        // Link loss and recovery.
        fill_plan_frame(8'h05, 8'h00);
        run_frame("pre_loss", -1, 1'b0, 25, 0, 5);
        idle(LOST - 20);
        check_val("link ok", 32'(link_lost), 32'd0);
        idle(30);
        check_val("link lost", 32'(link_lost), 32'd1);
        run_frame("relink", -1, 1'b0, 25, 0, 5);

        // Randomized frames with one fault class per frame.
        for (int f = 0; f < 20; f++) begin
            int  kind;
            int  err_pos;
            int  stop;
            bit  efe;
            fb[0] = 8'h0F;
            for (int i = 1; i < 24; i++) fb[i] = 8'($urandom);
            fb[24]  = 8'h00;
            err_pos = -1;
            efe     = 1'b0;
            stop    = 25;
            kind    = int'($urandom_range(9, 0));
            case (kind)
                0: fb[0] = 8'h10 | 8'($urandom);
                1: err_pos = int'($urandom_range(24, 0));
                2: begin
                    err_pos = int'($urandom_range(24, 0));
                    efe     = 1'b1;
                end
                3: fb[24] = 8'h80 | 8'($urandom);
                4: stop = int'($urandom_range(24, 1));
                5: fb[24] = {2'b00, 2'($urandom), 4'h4};
                default: ;
            endcase
            run_frame("rnd", err_pos, efe, stop, 0, 20);
        end

        // Reset in the middle of a frame after a commit with all flags set.
        fill_plan_frame(8'h0F, 8'h00);
        run_frame("pre_rst", -1, 1'b0, 25, 0, 5);
        ch_sel = 4'd0;
        idle(GAP + 130);
        send_frame(-1, 1'b0, 6, 0, 2);
        resetn = 1'b0;
        #1;
        check_val("midrst rx_en", 32'(rx_en), 32'd0);
        check_val("midrst link_lost", 32'(link_lost), 32'd1);
        check_val("midrst err_cnt", 32'(err_cnt), 32'd0);
        check_val("midrst outputs", 32'({ch_data, ch17, ch18, failsafe, frame_lost, frame_valid}), 32'd0);
`ifdef SBUS2_FOOTER_EN
        check_val("midrst slot", 32'(sbus2_slot), 32'd0);
`endif
        mdl_err = 0;
        @(negedge clk);
        resetn = 1'b1;
        idle(2);
        check_val("post rst rx_en", 32'(rx_en), 32'd1);
        check_val("post rst ch_data", 32'(ch_data), 32'd0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            idle(GAP + 5);
            send_byte(8'hA5, 1'b0, 1'b0);
            if (mdl_err < 255) mdl_err++;
            if (i == 100 || i == 254 || i == 299) check_val("err_sat", 32'(err_cnt), 32'(mdl_err));
        end
        check_val("err_cnt held", 32'(err_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
